// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory load/store unit
//
// Purpose: access-size encodings, FSM state enum, legal read-latency range,
//          the response pipeline entry type and the misalignment rule.
// Ports:   none (package).
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // Size 11 is never legal; halves need addr[0]=0, words need addr[1:0]=00.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane placement for stores and lane extract/extend for loads
//
// Purpose: purely combinational lane steering between a 32-bit memory word
//          and a right-aligned request/response value (little-endian lanes).
// Ports:
//   size_i        access size (SZ_B/SZ_H/SZ_W, 11 illegal)
//   addr_lo_i     byte offset within the word
//   unsigned_i    1 = zero-extend loads, 0 = sign-extend
//   wdata_i       right-aligned store data
//   rword_i       current memory word for loads
//   misaligned_o  access is misaligned or illegal
//   be_o          store byte enables (all zero when misaligned)
//   wword_o       store data replicated onto its lanes
//   rdata_o       extracted and extended load data (zero when misaligned)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    misaligned_o = is_misaligned(size_i, addr_lo_i);
    // Move the addressed lane(s) down to bit 0 before extension.
    shifted      = rword_i >> {addr_lo_i, 3'b000};
    be_o         = 4'b0000;
    wword_o      = 32'h0;
    rdata_o      = 32'h0;
    if (!misaligned_o) begin
      case (size_i)
        SZ_B: begin
          be_o    = 4'b0001 << addr_lo_i;
          wword_o = {4{wdata_i[7:0]}};
          rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        end
        SZ_H: begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wword_o = {2{wdata_i[15:0]}};
          rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        end
        SZ_W: begin
          be_o    = 4'b1111;
          wword_o = wdata_i;
          rdata_o = rword_i;
        end
        default: begin
          be_o    = 4'b0000;
          wword_o = 32'h0;
          rdata_o = 32'h0;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - word-organised data memory with byte/half/word load-store access
//
// Purpose: clears the array after reset (one word per cycle), then accepts one
//          request per cycle and returns one response RD_LAT cycles later.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in RUN)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                  request fields
//   rsp_valid, rsp_rdata,
//   rsp_err                    single-cycle response, data/err zero when idle
//   init_busy                  array clear in progress
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;
  // Out-of-range latencies are clamped onto the supported 1..2 range.
  localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                       (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              ready_q;
  logic              busy_q;

  logic [31:0]       mem_q [DEPTH];
  rsp_t              pipe_q [LAT];
  rsp_t              stage_d;

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       ld_data;

  assign idx    = req_addr[ADDR_W-1:2];
  // A request arriving on the reset edge is discarded along with everything else.
  assign accept = req_valid && ready_q && !rst;

  dmem_lane_align u_align (
    .size_i       (req_size),
    .addr_lo_i    (req_addr[1:0]),
    .unsigned_i   (req_unsigned),
    .wdata_i      (req_wdata),
    .rword_i      (mem_q[idx]),
    .misaligned_o (misaligned),
    .be_o         (be),
    .wword_o      (wword),
    .rdata_o      (ld_data)
  );

  // FSM with registered ready/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          state_q <= RUN;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array: cleared word by word in INIT, masked lane writes in RUN.
  // Loads read mem_q combinationally at their acceptance edge, so they
  // already see every store committed on an earlier edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= 32'h0;
      end else if (accept && req_we) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) begin
            mem_q[idx][8*k +: 8] <= wword[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    stage_d = '0;
    if (accept) begin
      stage_d.valid = 1'b1;
      stage_d.err   = misaligned;
      stage_d.rdata = req_we ? 32'h0 : ld_data;
    end
  end

  // Response pipeline; idle entries are all-zero so outputs stay clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign req_ready = ready_q;
  assign init_busy = busy_q;
  assign rsp_valid = pipe_q[LAT-1].valid;
  assign rsp_err   = pipe_q[LAT-1].err;
  assign rsp_rdata = pipe_q[LAT-1].rdata;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu at RD_LAT 1 and 2
module tb_data_mem_lsu;

  localparam int AW    = 6;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } ex_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic        r1_ready, r1_valid, r1_err, r1_busy;
  logic [31:0] r1_rdata;
  logic        r2_ready, r2_valid, r2_err, r2_busy;
  logic [31:0] r2_rdata;

  logic [7:0] mmem [4*DEPTH];
  int         init_left;
  ex_t        e1, e2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_W(AW), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r1_valid),
    .rsp_rdata(r1_rdata), .rsp_err(r1_err), .init_busy(r1_busy)
  );

  data_mem_lsu #(.ADDR_W(AW), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r2_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r2_valid),
    .rsp_rdata(r2_rdata), .rsp_err(r2_err), .init_busy(r2_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, responses computed from the access rules.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [AW-1:0] addr, input logic [31:0] wd, output ex_t r);
    logic   mis;
    int     n;
    longint v;
    mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    r = '{v: 1'b1, e: 1'b0, d: 32'h0};
    if (mis) begin
      r.e = 1'b1;
    end else begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) mmem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v |= longint'(mmem[int'(addr) + i]) << (8*i);
        if (!uns && v[8*n-1]) v |= ~((longint'(1) << (8*n)) - 1);
        r.d = v[31:0];
      end
    end
  endtask

  task automatic check_outputs();
    chk("u1_rsp_valid", r1_valid, e1.v);
    chk("u1_rsp_err",   r1_err,   e1.e);
    chk("u1_rsp_rdata", r1_rdata, e1.d);
    chk("u2_rsp_valid", r2_valid, e2.v);
    chk("u2_rsp_err",   r2_err,   e2.e);
    chk("u2_rsp_rdata", r2_rdata, e2.d);
  endtask

  // One clock cycle with the given request presented.
  task automatic cyc(input logic v, input logic we, input logic [1:0] size, input logic uns,
                     input logic [AW-1:0] addr, input logic [31:0] wd);
    ex_t nw;
    req_valid    = v;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    chk("u1_req_ready", r1_ready, init_left == 0);
    chk("u2_req_ready", r2_ready, init_left == 0);
    chk("u1_init_busy", r1_busy,  init_left != 0);
    chk("u2_init_busy", r2_busy,  init_left != 0);
    nw = '0;
    if (v && init_left == 0) model_req(we, size, uns, addr, wd, nw);
    @(posedge clk);
    #1;
    if (init_left > 0) init_left--;
    e2 = e1;
    e1 = nw;
    check_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      init_left = DEPTH;
      e1 = '0;
      e2 = '0;
      for (int i = 0; i < 4*DEPTH; i++) mmem[i] = 8'h00;
      check_outputs();
      chk("u1_ready_rst", r1_ready, 1'b0);
      chk("u2_ready_rst", r2_ready, 1'b0);
      chk("u1_busy_rst",  r1_busy,  1'b1);
      chk("u2_busy_rst",  r2_busy,  1'b1);
    end
    rst = 1'b0;
  endtask

  task automatic ld_const(input string tag, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] addr, input logic [31:0] exp);
    cyc(1'b1, 1'b0, size, uns, addr, 32'h0);
    chk(tag, r1_rdata, exp);
  endtask

  task automatic err_req(input string tag, input logic we, input logic [1:0] size,
                         input logic [AW-1:0] addr);
    cyc(1'b1, we, size, 1'b0, addr, 32'hFFFF_FFFF);
    chk(tag, {r1_valid, r1_err}, 2'b11);
    chk({tag, "_rdata"}, r1_rdata, 32'h0);
  endtask

  task automatic run_init_and_clear_check();
    // Requests offered during INIT must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b1, 2'b10, 1'b0, AW'($urandom_range(0, 15) * 4), $urandom);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ld_const("clear_word", 2'b10, 1'b0, AW'(i * 4), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
    init_left = DEPTH; e1 = '0; e2 = '0;

    do_reset();
    run_init_and_clear_check();

    // Lane extraction and extension.
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 6'h08, 32'hA1B2_C3D4);
    ld_const("lb_9",   2'b00, 1'b0, 6'h09, 32'hFFFF_FFC3);
    ld_const("lbu_b",  2'b00, 1'b1, 6'h0B, 32'h0000_00A1);
    ld_const("lh_a",   2'b01, 1'b0, 6'h0A, 32'hFFFF_A1B2);
    ld_const("lw_8",   2'b10, 1'b0, 6'h08, 32'hA1B2_C3D4);

    // Back-to-back store then load on the same word.
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 6'h09, 32'h0000_0055);
    ld_const("sb_lw_8", 2'b10, 1'b0, 6'h08, 32'hA1B2_55D4);
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 6'h0A, 32'h0000_1234);
    ld_const("sh_lw_8", 2'b10, 1'b0, 6'h08, 32'h1234_55D4);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);

    // Misaligned / illegal accesses leave memory untouched.
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 6'h04, 32'h1122_3344);
    err_req("sw_6_err",  1'b1, 2'b10, 6'h06);
    err_req("lh_3_err",  1'b0, 2'b01, 6'h03);
    err_req("sz11_ld",   1'b0, 2'b11, 6'h04);
    err_req("sz11_st",   1'b1, 2'b11, 6'h04);
    err_req("sh_5_err",  1'b1, 2'b01, 6'h05);
    ld_const("lw_4_kept", 2'b10, 1'b0, 6'h04, 32'h1122_3344);

    // Ten consecutive requests, then random traffic.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 15) * 4), $urandom);
    end
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
    end

    // Reset with two loads in flight.
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 6'h00, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 6'h00, 32'h0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    do_reset();
    run_init_and_clear_check();
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
